// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - MDU operation codes as issued by the datapath controller
//   - FSM state encoding for the handshake controller
//   - INT_MIN, the one signed dividend whose negation overflows
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational arithmetic core of the MDU.
//   op          in  4   operation code (mdu_pkg)
//   D1          in  32  rs operand (multiplicand / dividend)
//   D2          in  32  rt operand (multiplier / divisor)
//   res_hi      out 32  HI result (product[63:32] or remainder)
//   res_lo      out 32  LO result (product[31:0] or quotient)
//   div_by_zero out 1   DIV/DIVU with D2 == 0; HI/LO must not be updated
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic [63:0] prod_signed_s;
  logic [63:0] prod_unsigned_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] udiv_den_s;
  logic [31:0] sdiv_den_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] mq_s;
  logic [31:0] mr_s;
  logic        d2_zero_s;

  // Operand conditioning: sign-extended products, magnitudes and zero-safe divisors.
  always_comb begin
    prod_signed_s   = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
    prod_unsigned_s = {32'd0, D1} * {32'd0, D2};
    a_mag_s         = D1[31] ? (32'd0 - D1) : D1;
    b_mag_s         = D2[31] ? (32'd0 - D2) : D2;
    d2_zero_s       = (D2 == 32'd0);
    // A zero divisor is replaced by 1 so the dividers never see 0; the result is discarded anyway.
    udiv_den_s      = d2_zero_s ? 32'd1 : D2;
    sdiv_den_s      = d2_zero_s ? 32'd1 : b_mag_s;
    uq_s            = D1 / udiv_den_s;
    ur_s            = D1 % udiv_den_s;
    mq_s            = a_mag_s / sdiv_den_s;
    mr_s            = a_mag_s % sdiv_den_s;
  end

  // Result selection and sign fix-up per operation.
  always_comb begin
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    div_by_zero = 1'b0;
    case (op)
      MDU_MULT: begin
        res_hi = prod_signed_s[63:32];
        res_lo = prod_signed_s[31:0];
      end
      MDU_MULTU: begin
        res_hi = prod_unsigned_s[63:32];
        res_lo = prod_unsigned_s[31:0];
      end
      MDU_DIV: begin
        div_by_zero = d2_zero_s;
        if ((D1 == INT_MIN) && (D2 == 32'hFFFF_FFFF)) begin
          // Quotient overflows; the architected result wraps to INT_MIN with no remainder.
          res_lo = INT_MIN;
          res_hi = 32'd0;
        end else begin
          // Quotient truncates toward zero; remainder takes the dividend's sign.
          res_lo = (D1[31] ^ D2[31]) ? (32'd0 - mq_s) : mq_s;
          res_hi = D1[31] ? (32'd0 - mr_s) : mr_s;
        end
      end
      MDU_DIVU: begin
        div_by_zero = d2_zero_s;
        res_lo      = uq_s;
        res_hi      = ur_s;
      end
      default: begin
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit owning the HI/LO registers.
//   clk    in  1   rising-edge clock
//   rst_n  in  1   asynchronous active-low reset
//   start  in  1   issue request, sampled on rising clk (ignored while busy)
//   op     in  4   operation code (mdu_pkg)
//   D1     in  32  rs operand
//   D2     in  32  rt operand
//   busy   out 1   operation in flight
//   done   out 1   one-cycle pulse in the first cycle HI/LO show the new result
//   hi     out 32  HI register
//   lo     out 32  LO register
// The result is computed at issue and held internally; the counter only models
// the architectural latency, so HI/LO never expose an in-flight value.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  mdu_state_e  state_r;
  logic [4:0]  count_r;
  logic [31:0] res_hi_r;
  logic [31:0] res_lo_r;
  logic        dbz_r;

  logic [31:0] calc_hi_s;
  logic [31:0] calc_lo_s;
  logic        calc_dbz_s;

  mdu_calc u_calc (
    .op          (op),
    .D1          (D1),
    .D2          (D2),
    .res_hi      (calc_hi_s),
    .res_lo      (calc_lo_s),
    .div_by_zero (calc_dbz_s)
  );

  // Issue/latency FSM, result latch and HI/LO commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      count_r  <= 5'd0;
      res_hi_r <= 32'd0;
      res_lo_r <= 32'd0;
      dbz_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            case (op)
              MDU_MULT, MDU_MULTU: begin
                res_hi_r <= calc_hi_s;
                res_lo_r <= calc_lo_s;
                dbz_r    <= 1'b0;
                count_r  <= MULT_LOAD;
                busy     <= 1'b1;
                state_r  <= RUN;
              end
              MDU_DIV, MDU_DIVU: begin
                res_hi_r <= calc_hi_s;
                res_lo_r <= calc_lo_s;
                dbz_r    <= calc_dbz_s;
                count_r  <= DIV_LOAD;
                busy     <= 1'b1;
                state_r  <= RUN;
              end
              MDU_MTHI: hi <= D1;
              MDU_MTLO: lo <= D1;
              default:  state_r <= IDLE;
            endcase
          end
        end
        RUN: begin
          if (count_r == 5'd0) begin
            // Divide-by-zero keeps the architectural HI/LO but still completes the handshake.
            if (!dbz_r) begin
              hi <= res_hi_r;
              lo <= res_lo_r;
            end
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= IDLE;
          end else begin
            count_r <= count_r - 5'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Multi-cycle multiply/divide unit.
- Responder for MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO. The single-cycle ALU cannot execute these, so the datapath controller issues them here.
- Owns the HI/LO registers. Exposes a busy/done handshake so the datapath can stall MFHI/MFLO and further MDU ops until the result is committed.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (range 1..31).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (range 1..31).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue request, sampled on rising clk
- op  in  4  operation code (see package)
- D1  in  32  rs operand (dividend / multiplicand / MT source)
- D2  in  32  rt operand (divisor / multiplier)
- busy  out  1  operation in flight; datapath must stall MDU-dependent instrs
- done  out  1  one-cycle pulse in the cycle HI/LO first show the new result
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, counter=0, latched result cleared, FSM=IDLE. Asserting reset mid-operation aborts it; HI/LO stay 0.
- FSM states are IDLE and RUN.

IDLE, start=1 (edge ending cycle T):
- MULT/MULTU/DIV/DIVU: compute the result from D1/D2 sampled at T into internal res_hi/res_lo. Load counter = N-1, where N = MULT_CYCLES or DIV_CYCLES. Go to RUN. busy=1 from cycle T+1.
- MTHI: hi<=D1. MTLO: lo<=D1. Both stay in IDLE with busy=0; the value is visible in T+1.
- NOP or undefined op codes: ignored, no state change.

RUN:
- Counter decrements each cycle.
- In the cycle where counter==0, at its closing edge: hi<=res_hi, lo<=res_lo, busy<=0, done<=1, go to IDLE.
- busy is therefore high for exactly N cycles, T+1..T+N.
- done and the new hi/lo appear in T+N+1; done returns to 0 in T+N+2.

start while busy=1:
- Ignored entirely, including MTHI/MTLO.
- D1/D2 changes during RUN have no effect.

done and start in the same cycle:
- Accepted normally; the new op proceeds as if started from IDLE.

Arithmetic:
- MULT: signed 32x32 -> 64. hi = product[63:32], lo = product[31:0].
- MULTU: unsigned 32x32 -> 64, same hi/lo split.
- DIV: signed. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- DIV with 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (D2=0, DIV or DIVU): the op still occupies DIV_CYCLES and pulses done, but hi/lo are left unchanged.

Outputs:
- hi/lo are registered; they never reflect the in-flight result before commit.

Decomposition:
- Package mdu_pkg holds:
  - op codes: MDU_NOP=4'd0, MDU_MULT=4'd1, MDU_MULTU=4'd2, MDU_DIV=4'd3, MDU_DIVU=4'd4, MDU_MTHI=4'd5, MDU_MTLO=4'd6;
  - the FSM state enum (IDLE, RUN);
  - the INT_MIN constant 32'h80000000.
- One natural sub-module: mdu_calc.
  - Combinational; takes op, D1, D2.
  - Produces res_hi, res_lo, div_by_zero.
  - Isolates the signed/unsigned and edge-case arithmetic from the handshake FSM.

Test Plan:
- Reset/MT:
  - Stimulus: rst_n=0 then release; start MTHI D1=0x12345678; next cycle start MTLO D1=0x9ABCDEF0.
  - Response: hi=lo=0 after reset; hi=0x12345678 one cycle after MTHI, lo=0x9ABCDEF0 one cycle after MTLO; busy never asserted.
- MULT signed:
  - Stimulus: D1=0xFFFFFFFE (-2), D2=0x00000003, start at T.
  - Response: busy=1 for exactly 5 cycles; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 for one cycle.
- MULTU and DIVU:
  - Stimulus: MULTU D1=D2=0xFFFFFFFF; then DIVU D1=100, D2=7.
  - Response: MULTU gives hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles; DIVU gives lo=14, hi=2 after 10 busy cycles.
- DIV edge cases:
  - Stimulus: DIV -7/2; DIV 0x80000000/0xFFFFFFFF; DIV 5/0 with hi/lo pre-set to 0xAA/0xBB.
  - Response: lo=0xFFFFFFFD, hi=0xFFFFFFFF; lo=0x80000000, hi=0; hi/lo stay 0xAA/0xBB with done still pulsed after 10 cycles.
- Start-while-busy and back-to-back:
  - Stimulus: issue MTHI and a second MULT during the busy window of a DIV; then issue a new MULT in the done cycle.
  - Response: both in-window requests are ignored and hi/lo match the DIV result; the back-to-back MULT is accepted, busy is immediately re-asserted for 5 cycles.
- Reset mid-operation:
  - Stimulus: start MULT 3x4, assert rst_n=0 at the 3rd busy cycle, then release.
  - Response: busy=0, done=0, hi=lo=0 immediately (async); no commit occurs afterwards.
